// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide unit producing the Z-high/Z-low pair.
// Multiply: radix-2 Booth, one bit per cycle, full 2*WIDTH product.
// Divide: restoring division on magnitudes, sign fix-up in FIX.
// Result and done appear 33 edges after the start edge; the DONE cycle
// also accepts a start so back-to-back operations are 34 edges apart.
// Ports:
//   clk, clr       : clock, asynchronous active-high reset
//   start, op      : begin operation (0 = multiply, 1 = divide)
//   a_in, b_in     : operand A (Y register), operand B (BusMuxOut)
//   zhi_output     : product high word or remainder
//   zlo_output     : product low word or quotient
//   busy, done     : in CALC/FIX, one-cycle result-valid pulse
//   div_zero       : last completed operation was a divide by zero
`timescale 1ns/1ps
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] zhi_output,
    output logic [WIDTH-1:0] zlo_output,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic             load_c, step_c, fix_c;
    logic [CNT_W-1:0] cnt_q;

    // Operation context captured on the start edge
    logic             op_q;
    logic             a_neg_q;
    logic             q_neg_q;
    logic             dvz_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] m_q;

    // Shared working registers: Booth {hi, lo, bit} or divider {rem, quo}
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             bit_q;

    logic [WIDTH:0]   m_ext, booth_sum, shifted, hi_step;
    logic [WIDTH-1:0] lo_step, a_mag, b_mag, zhi_fix, zlo_fix;
    logic             ge;

    // Next-state and control strobes
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        fix_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    load_c  = 1'b1;
                end
            end
            CALC: begin
                step_c = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                fix_c   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = CALC;
                    load_c  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes for the divider
    always_comb begin
        a_mag = a_in[WIDTH-1] ? -a_in : a_in;
        b_mag = b_in[WIDTH-1] ? -b_in : b_in;
    end

    // One iteration of Booth or restoring division
    always_comb begin
        m_ext     = {m_q[WIDTH-1], m_q};
        booth_sum = hi_q;
        shifted   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        ge        = (shifted >= {1'b0, m_q});
        hi_step   = hi_q;
        lo_step   = lo_q;
        if (!op_q) begin
            case ({lo_q[0], bit_q})
                2'b01:   booth_sum = hi_q + m_ext;
                2'b10:   booth_sum = hi_q - m_ext;
                default: booth_sum = hi_q;
            endcase
            // Arithmetic shift right of the {hi, lo, bit} chain; hi has a
            // guard bit so subtracting the most negative multiplicand fits.
            hi_step = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            lo_step = {booth_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_step = ge ? (shifted - {1'b0, m_q}) : shifted;
            lo_step = {lo_q[WIDTH-2:0], ge};
        end
    end

    // Final result with sign correction / divide-by-zero override
    always_comb begin
        zhi_fix = hi_q[WIDTH-1:0];
        zlo_fix = lo_q;
        if (op_q) begin
            if (dvz_q) begin
                zhi_fix = a_q;
                zlo_fix = '1;
            end else begin
                zhi_fix = a_neg_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
                zlo_fix = q_neg_q ? -lo_q : lo_q;
            end
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            a_neg_q    <= 1'b0;
            q_neg_q    <= 1'b0;
            dvz_q      <= 1'b0;
            a_q        <= '0;
            m_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            bit_q      <= 1'b0;
            zhi_output <= '0;
            zlo_output <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == CALC) || (state_d == FIX);
            done    <= (state_d == DONE);
            if (load_c) begin
                cnt_q   <= '0;
                op_q    <= op;
                a_q     <= a_in;
                a_neg_q <= a_in[WIDTH-1];
                q_neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                dvz_q   <= (b_in == '0);
                hi_q    <= '0;
                bit_q   <= 1'b0;
                m_q     <= op ? b_mag : b_in;
                lo_q    <= op ? a_mag : a_in;
            end else if (step_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
                hi_q  <= hi_step;
                lo_q  <= lo_step;
                bit_q <= lo_q[0];
            end
            if (fix_c) begin
                zhi_output <= zhi_fix;
                zlo_output <= zlo_fix;
                div_zero   <= op_q & dvz_q;
            end
        end
    end

endmodule
